// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared BCD constants, digit type and digit validity helper
//               for the multi-decade BCD counter.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int          BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;
    localparam logic [3:0]  BCD_MIN = 4'd0;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    // A nibble is a legal decimal digit only in the range 0..9.
    function automatic logic bcd_valid(input bcd_digit_t i_digit);
        return (i_digit <= BCD_MAX);
    endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit_step.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_step
// Description : Combinational next-value logic for one BCD decade. With a
//               carry/borrow in, the digit steps by one in the chosen
//               direction and reports wrap-around on o_cout.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_step
    import bcd_pkg::*;
(
    input  wire bcd_digit_t i_digit,
    input  wire logic       i_up,
    input  wire logic       i_cin,
    output bcd_digit_t      o_next,
    output logic            o_cout
);

    // Step the digit only when a carry/borrow arrives from the lower decade.
    always_comb begin
        o_next = i_digit;
        o_cout = 1'b0;
        if (i_cin) begin
            if (i_up) begin
                // >= also folds any illegal nibble back to 0
                if (i_digit >= BCD_MAX) begin
                    o_next = BCD_MIN;
                    o_cout = 1'b1;
                end else begin
                    o_next = i_digit + 4'd1;
                end
            end else begin
                if (i_digit == BCD_MIN) begin
                    o_next = BCD_MAX;
                    o_cout = 1'b1;
                end else if (i_digit > BCD_MAX) begin
                    o_next = BCD_MAX;
                end else begin
                    o_next = i_digit - 4'd1;
                end
            end
        end
    end

endmodule : bcd_digit_step
`default_nettype wire

// File: rtl/bcd_counter_n.sv
`default_nettype none
// ============================================================================
// Module      : bcd_counter_n
// Description : DIGITS-decade BCD up/down counter with enable, validated
//               parallel load, wrap-around and registered carry/borrow/error
//               pulses. Count is packed BCD, least significant digit in [3:0].
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  in_en,
    input  wire logic                  in_up,
    input  wire logic                  in_load,
    input  wire logic [4*DIGITS-1:0]   in_data,
    output logic      [4*DIGITS-1:0]   out_count,
    output logic                       out_carry,
    output logic                       out_borrow,
    output logic                       out_tc,
    output logic                       out_err
);

    logic [4*DIGITS-1:0] r_count_q;
    logic [4*DIGITS-1:0] w_count_d;
    logic                r_carry_q,  w_carry_d;
    logic                r_borrow_q, w_borrow_d;
    logic                r_err_q,    w_err_d;

    logic [DIGITS:0]     w_chain;
    logic [4*DIGITS-1:0] w_stepped;
    logic [DIGITS-1:0]   w_nib_ok;
    logic [DIGITS-1:0]   w_is_nine;
    logic [DIGITS-1:0]   w_is_zero;

    // The least significant decade always receives the step request.
    assign w_chain[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_step u_step (
                .i_digit (r_count_q[4*gi +: 4]),
                .i_up    (in_up),
                .i_cin   (w_chain[gi]),
                .o_next  (w_stepped[4*gi +: 4]),
                .o_cout  (w_chain[gi+1])
            );
            assign w_nib_ok[gi]  = bcd_valid(in_data[4*gi +: 4]);
            assign w_is_nine[gi] = (r_count_q[4*gi +: 4] == BCD_MAX);
            assign w_is_zero[gi] = (r_count_q[4*gi +: 4] == BCD_MIN);
        end
    endgenerate

    // Priority mux: load (validated) beats count, count beats hold.
    always_comb begin
        w_count_d  = r_count_q;
        w_carry_d  = 1'b0;
        w_borrow_d = 1'b0;
        w_err_d    = 1'b0;
        if (in_load) begin
            if (&w_nib_ok) begin
                w_count_d = in_data;
            end else begin
                w_err_d = 1'b1;
            end
        end else if (in_en) begin
            w_count_d = w_stepped;
            // a carry out of the top decade means the whole count wrapped
            if (in_up) begin
                w_carry_d = w_chain[DIGITS];
            end else begin
                w_borrow_d = w_chain[DIGITS];
            end
        end
    end

    // Count and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q  <= '0;
            r_carry_q  <= 1'b0;
            r_borrow_q <= 1'b0;
            r_err_q    <= 1'b0;
        end else begin
            r_count_q  <= w_count_d;
            r_carry_q  <= w_carry_d;
            r_borrow_q <= w_borrow_d;
            r_err_q    <= w_err_d;
        end
    end

    assign out_count  = r_count_q;
    assign out_carry  = r_carry_q;
    assign out_borrow = r_borrow_q;
    assign out_err    = r_err_q;
    assign out_tc     = (in_up & (&w_is_nine)) | (~in_up & (&w_is_zero));

endmodule : bcd_counter_n
`default_nettype wire
